// File: rtl/spi_2m_pkg.sv
// Shared definitions for the two-requester SPI DAC scheduler.
// Holds the FSM state encoding, the slave address values and the frame length.
// Optional build macro used by the scheduler: SPI_SCHED_FIXED_PRIO_EN.
package spi_2m_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic ADDR_S0 = 1'b0;
  localparam logic ADDR_S1 = 1'b1;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_BITS = DATA_W_DEF + 1;

  // Frame length (address bit followed by the DAC word) for any word width.
  function automatic int frameBits(input int dataW);
    return dataW + 1;
  endfunction

endpackage

// File: rtl/spi_2m_clkgen.sv
// Half-period timebase for the SPI clock.
// Counts 0..CLK_DIV-1 and presents tick while the count sits at CLK_DIV-1,
// so the scheduler sees one tick every CLK_DIV cycles.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset
//   clear  - restart the half-period from zero (asserted on grant)
//   tick   - one-cycle pulse at the end of each half-period
module spi_2m_clkgen
  import spi_2m_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins so the first half-period after a grant is a full
  // CLK_DIV cycles long; otherwise wrap at the top of the range.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  // Half-period counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_2m_sched.sv
// Two-requester SPI master scheduler for the dual-slave DAC pair.
// Arbitrates between two word-update requests and serialises each grant as
// one frame: slave-address bit followed by the DAC word, MSB first.
// Build option: define SPI_SCHED_FIXED_PRIO_EN for fixed priority (req[0]
// wins ties); otherwise round-robin with slave 0 winning the first tie.
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   req[1:0]       - per-slave update request levels, held until ack
//   data0, data1   - DAC words for slave 0 / slave 1, captured at grant
//   ack[1:0]       - one-cycle pulse when that slave's frame completes
//   busy           - high from grant through the end of the inter-frame gap
//   sclk, cs, mosi - SPI bus (sclk idles low, cs active-low)
module spi_2m_sched
  import spi_2m_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        ack,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi
);

  localparam int FB  = frameBits(DATA_W);
  localparam int BCW = $clog2(FB + 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BCW-1:0]    bitCnt_q;
  logic              grant_q;
  logic              tick;
  logic              grantNow;
  logic              grantIdx;

  assign grantNow = (state_q == IDLE) && (req != 2'b00);

`ifdef SPI_SCHED_FIXED_PRIO_EN
  // Fixed priority: slave 0 always wins.
  always_comb begin
    grantIdx = req[0] ? ADDR_S0 : ADDR_S1;
  end
`else
  logic last_q;

  // Round-robin: on a tie grant the requester not served last; a lone
  // request is granted directly.
  always_comb begin
    grantIdx = req[1] ? ADDR_S1 : ADDR_S0;
    if (req == 2'b11) begin
      grantIdx = ~last_q;
    end
  end

  // Remember who was served; reset to slave 1 so slave 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= ADDR_S1;
    end else if (grantNow) begin
      last_q <= grantIdx;
    end
  end
`endif

  spi_2m_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) uClkgen (
    .clk  (clk),
    .reset(reset),
    .clear(grantNow),
    .tick (tick)
  );

  // Frame sequencer. All bus outputs are registered here. The address bit is
  // driven straight onto mosi at grant, so the shift register only carries
  // the data word; each falling sclk edge presents its next MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      grant_q  <= ADDR_S0;
      ack      <= 2'b00;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      ack <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grantNow) begin
            grant_q  <= grantIdx;
            shift_q  <= grantIdx ? data1 : data0;
            bitCnt_q <= '0;
            cs       <= 1'b0;
            mosi     <= grantIdx;
            busy     <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              sclk     <= 1'b0;
              mosi     <= shift_q[DATA_W-1];
              shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
              bitCnt_q <= bitCnt_q + 1'b1;
              if (bitCnt_q == BCW'(FB - 1)) begin
                state_q <= HOLD;
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs      <= 1'b1;
            mosi    <= 1'b0;
            ack     <= grant_q ? 2'b10 : 2'b01;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_2m_sched.sv
// Testbench for spi_2m_sched: randomized request rounds on a CLK_DIV=4
// instance checked by a frame scoreboard, plus a reset-abort case and a
// back-to-back case on a CLK_DIV=1 instance.
module tb_spi_2m_sched;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [1:0] ack;
  logic       busy, sclk, cs, mosi;

  logic [1:0] reqB = 2'b00;
  logic [7:0] dataB0 = 8'h00;
  logic [7:0] dataB1 = 8'h00;
  logic [1:0] ackB;
  logic       busyB, sclkB, csB, mosiB;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] ackExp;
    logic [8:0] frame;
  } exp_t;

  exp_t expQ[$];
  bit   lastServed = 1'b1;

  spi_2m_sched #(.CLK_DIV(H), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .busy(busy), .sclk(sclk), .cs(cs), .mosi(mosi)
  );

  spi_2m_sched #(.CLK_DIV(1), .DATA_W(8)) dutB (
    .clk(clk), .reset(reset), .req(reqB), .data0(dataB0), .data1(dataB1),
    .ack(ackB), .busy(busyB), .sclk(sclkB), .cs(csB), .mosi(mosiB)
  );

  // Free-running clock and an edge counter used as the time reference.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the H=4 instance: collects the bits seen on each
  // rising sclk, checks edge timing against the frame start, and on each ack
  // pops the frame the model predicted.
  logic       prevCs = 1'b1, prevSclk = 1'b0, prevMosi = 1'b0, prevBusy = 1'b0;
  logic [1:0] prevAck = 2'b00;
  logic [8:0] bits = '0;
  int         nbits = 0;
  int         t0 = 0;
  bit         glitch = 1'b0;
  exp_t       popped;

  always @(negedge clk) begin
    if (reset) begin
      prevCs = 1'b1; prevSclk = 1'b0; prevMosi = 1'b0; prevBusy = 1'b0; prevAck = 2'b00;
    end else begin
      if (prevCs && !cs) begin
        t0 = cyc; nbits = 0; bits = '0; glitch = 1'b0;
      end
      if (sclk && prevSclk && (mosi !== prevMosi)) glitch = 1'b1;
      if (!prevSclk && sclk) begin
        checkOutput("sclkRiseTime", cyc - t0, H + 2 * nbits * H);
        bits = {bits[7:0], mosi};
        nbits++;
      end
      if (prevAck != 2'b00) checkOutput("ackWidth", ack, 2'b00);
      if (ack != 2'b00 && prevAck == 2'b00) begin
        if (expQ.size() == 0) begin
          compared++; mismatched++;
          $display("[TB] FAIL unexpectedAck: actual=%b required=no ack", ack);
        end else begin
          popped = expQ.pop_front();
          checkOutput("ackIndex", ack, popped.ackExp);
          checkOutput("frameBits", bits, popped.frame);
          checkOutput("bitCount", nbits, 9);
          checkOutput("ackTime", cyc - t0, 19 * H);
          checkOutput("mosiStable", glitch, 1'b0);
        end
      end
      if (prevBusy && !busy) checkOutput("busyFallTime", cyc - t0, 20 * H);
      prevCs = cs; prevSclk = sclk; prevMosi = mosi; prevBusy = busy; prevAck = ack;
    end
  end

  // Light monitor for the H=1 instance: frame start time, captured bits,
  // and counts of frames started and acknowledged.
  logic       prevCsB = 1'b1, prevSclkB = 1'b0;
  logic [8:0] bitsB = '0;
  int         tB0 = 0, csFallsB = 0, acksB = 0;

  always @(negedge clk) begin
    if (reset) begin
      prevCsB = 1'b1; prevSclkB = 1'b0;
    end else begin
      if (prevCsB && !csB) begin tB0 = cyc; csFallsB++; bitsB = '0; end
      if (!prevSclkB && sclkB) bitsB = {bitsB[7:0], mosiB};
      if (ackB != 2'b00) acksB++;
      prevCsB = csB; prevSclkB = sclkB;
    end
  end

  // One round of requests: requester i wants n_i frames. The reference model
  // orders them by the arbitration rule and queues the expected frames, then
  // the requesters hold req and swap in their next word on the cycle after
  // each ack, dropping req after their last frame.
  task automatic applyStimulus(input int n0, input int n1, input logic [7:0] f0,
                               input logic [7:0] f1, input bit useFirst);
    logic [7:0] dq0[$];
    logic [7:0] dq1[$];
    int r0 = 0, r1 = 0, k0 = 0, k1 = 0, guard = 0, limit;
    bit pick;
    logic [1:0] dropNext = 2'b00;
    exp_t e;
    for (int i = 0; i < n0; i++) dq0.push_back((i == 0 && useFirst) ? f0 : 8'($urandom));
    for (int i = 0; i < n1; i++) dq1.push_back((i == 0 && useFirst) ? f1 : 8'($urandom));
    while (r0 < n0 || r1 < n1) begin
`ifdef SPI_SCHED_FIXED_PRIO_EN
      pick = (r0 < n0) ? 1'b0 : 1'b1;
`else
      if (r0 < n0 && r1 < n1) pick = ~lastServed;
      else pick = (r1 < n1);
`endif
      e.ackExp = pick ? 2'b10 : 2'b01;
      e.frame  = {pick, pick ? dq1[r1] : dq0[r0]};
      expQ.push_back(e);
      if (pick) r1++; else r0++;
      lastServed = pick;
    end
    @(posedge clk); #1;
    if (n0 > 0) data0 = dq0[0];
    if (n1 > 0) data1 = dq1[0];
    req = {n1 > 0, n0 > 0};
    limit = (n0 + n1) * (20 * H + 2) + 20;
    while ((req != 2'b00 || dropNext != 2'b00) && guard < limit) begin
      @(posedge clk); #1;
      guard++;
      if (dropNext[0]) begin
        dropNext[0] = 1'b0; k0++;
        if (k0 < n0) data0 = dq0[k0];
        else begin req[0] = 1'b0; data0 = 8'($urandom); end
      end
      if (dropNext[1]) begin
        dropNext[1] = 1'b0; k1++;
        if (k1 < n1) data1 = dq1[k1];
        else begin req[1] = 1'b0; data1 = 8'($urandom); end
      end
      if (ack[0] && req[0]) dropNext[0] = 1'b1;
      if (ack[1] && req[1]) dropNext[1] = 1'b1;
    end
    if (guard >= limit) begin
      compared++; mismatched++;
      $display("[TB] FAIL roundTimeout: actual=%0d cycles required<%0d", guard, limit);
      req = 2'b00;
    end
  endtask

  // Abort a slave-0 frame with reset mid-shift, then serve slave 1.
  task automatic resetTest();
    int guard = 0;
    int tr;
    @(posedge clk); #1;
    data0 = 8'hFF; req = 2'b01;
    while (cs !== 1'b0 && guard < 20) begin @(posedge clk); #1; guard++; end
    checkOutput("resetTest.csFell", cs, 1'b0);
    tr = cyc;
    repeat (38) @(posedge clk);
    #1;
    checkOutput("resetTest.preSclk", sclk, 1'b1);
    checkOutput("resetTest.preMosi", mosi, 1'b1);
    checkOutput("resetTest.elapsed", cyc - tr, 38);
    reset = 1'b1;
    #1;
    checkOutput("resetTest.cs", cs, 1'b1);
    checkOutput("resetTest.sclk", sclk, 1'b0);
    checkOutput("resetTest.mosi", mosi, 1'b0);
    checkOutput("resetTest.busy", busy, 1'b0);
    checkOutput("resetTest.ack", ack, 2'b00);
    req = 2'b00;
    lastServed = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(0, 1, 8'h00, 8'h00, 1'b0);
  endtask

  // H=1 back-to-back: slave 1 keeps req high and presents a new word on the
  // cycle after ack; the second frame must start at t0+21 and only once.
  task automatic backToBackTest();
    int guard = 0;
    int tFirst;
    @(posedge clk); #1;
    dataB1 = 8'hFF; reqB = 2'b10;
    while (csFallsB < 1 && guard < 10) begin @(posedge clk); #1; guard++; end
    checkOutput("b2b.firstGrant", csFallsB, 1);
    tFirst = tB0;
    guard = 0;
    while (ackB[1] !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    checkOutput("b2b.ackTime", cyc - tFirst, 19);
    checkOutput("b2b.frame1", bitsB, 9'h1FF);
    @(posedge clk); #1;
    dataB1 = 8'h5A;
    guard = 0;
    while (csFallsB < 2 && guard < 10) begin @(posedge clk); #1; guard++; end
    checkOutput("b2b.nextGrant", tB0 - tFirst, 21);
    guard = 0;
    while (ackB[1] !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    checkOutput("b2b.frame2", bitsB, 9'h15A);
    @(posedge clk); #1;
    reqB = 2'b00;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("b2b.frameCount", csFallsB, 2);
    checkOutput("b2b.ackCount", acksB, 2);
  endtask

  // Main sequence: reset values, directed rounds, random rounds, reset abort,
  // fast-clock back-to-back, then the summary.
  initial begin
    int n0, n1;
    reset = 1'b1;
    #1;
    checkOutput("reset.cs", cs, 1'b1);
    checkOutput("reset.sclk", sclk, 1'b0);
    checkOutput("reset.mosi", mosi, 1'b0);
    checkOutput("reset.ack", ack, 2'b00);
    checkOutput("reset.busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(1, 0, 8'hA5, 8'h00, 1'b1);
    applyStimulus(2, 1, 8'h3C, 8'hC3, 1'b1);
    for (int r = 0; r < 8; r++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n0 = 1;
      applyStimulus(n0, n1, 8'h00, 8'h00, 1'b0);
    end

    resetTest();
    backToBackTest();

    repeat (5) @(posedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
